// File: rtl/i3c_pkg.sv
// rtl/i3c_pkg.sv - shared encodings for the I3C SDR transfer sequencer
// Contents:
//   I3C_BCAST_ADDR     broadcast header address (7'h7E)
//   RW_WRITE / RW_READ  RW bit values appended to an address
//   cmd_op_e           PHY bit-command opcodes
//   ST_*               transfer FSM state codes
//   odd_par_bit()      T-bit for a written data byte
package i3c_pkg;

  localparam logic [6:0] I3C_BCAST_ADDR = 7'h7E;
  localparam logic       RW_WRITE       = 1'b0;
  localparam logic       RW_READ        = 1'b1;

  typedef enum logic [2:0] {
    OP_START  = 3'd0,
    OP_RSTART = 3'd1,
    OP_STOP   = 3'd2,
    OP_WRBIT  = 3'd3,
    OP_RDBIT  = 3'd4
  } cmd_op_e;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_START  = 4'd1;
  localparam logic [3:0] ST_HDR    = 4'd2;
  localparam logic [3:0] ST_HACK   = 4'd3;
  localparam logic [3:0] ST_RSTART = 4'd4;
  localparam logic [3:0] ST_ADDR   = 4'd5;
  localparam logic [3:0] ST_AACK   = 4'd6;
  localparam logic [3:0] ST_WDATA  = 4'd7;
  localparam logic [3:0] ST_WPAR   = 4'd8;
  localparam logic [3:0] ST_RDATA  = 4'd9;
  localparam logic [3:0] ST_RPAR   = 4'd10;
  localparam logic [3:0] ST_STOP   = 4'd11;

  // The SDR T-bit makes the nine-bit data+T word carry odd parity.
  function automatic logic odd_par_bit(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/i3c_bit_shifter.sv
// rtl/i3c_bit_shifter.sv - 8-bit shift register with bit counter for serial phases
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load, load_val  load a new byte and restart the bit count
//   shift, sin      shift left one place, sin enters at bit 0 (0 for shift-out)
//   data            current register contents
//   msb             bit currently presented for shift-out
//   last            the eighth bit of the phase is the current one
module i3c_bit_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       shift,
  input  logic       sin,
  output logic [7:0] data,
  output logic       msb,
  output logic       last
);

  logic [2:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= 8'h00;
      cnt  <= 3'd0;
    end else if (load) begin
      data <= load_val;
      cnt  <= 3'd0;
    end else if (shift) begin
      data <= {data[6:0], sin};
      cnt  <= cnt + 3'd1;
    end
  end

  assign msb  = data[7];
  assign last = (cnt == 3'd7);

endmodule

// File: rtl/i3c_sdr_xfer_ctrl.sv
// rtl/i3c_sdr_xfer_ctrl.sv - single-byte I3C SDR private transfer sequencer
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   en, dyn_addr                enable (checked in IDLE only), target address
//   tx_ready, tx_data           pending TX byte from the register file
//   tx_consume                  pulse: TX byte written and ACKed
//   rd_req, rx_ready            read request pulse, RX register free
//   rx_data, rx_push            received byte and its one-cycle valid pulse
//   busy, nack_err              transfer in progress, header/address NACK pulse
//   cmd_valid/op/bit, cmd_ready PHY command channel (one outstanding)
//   cmd_done, rsp_bit           PHY completion pulse and sampled SDA
module i3c_sdr_xfer_ctrl
  import i3c_pkg::*;
#(
  parameter logic [6:0] HDR_ADDR    = I3C_BCAST_ADDR,
  parameter bit         WR_PRIORITY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] dyn_addr,
  input  logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_consume,
  input  logic       rd_req,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_push,
  output logic       busy,
  output logic       nack_err,
  output logic       cmd_valid,
  output logic [2:0] cmd_op,
  output logic       cmd_bit,
  input  logic       cmd_ready,
  input  logic       cmd_done,
  input  logic       rsp_bit
);

  logic [3:0] state;
  logic       wait_done;   // a command was accepted and its cmd_done is due
  logic       rd_pend;
  logic       is_rd;
  logic [6:0] addr_q;
  logic [7:0] data_q;

  logic       done_ev;
  logic       wr_cand;
  logic       rd_cand;
  logic       start_xfer;
  logic       pick_rd;

  logic       sh_load;
  logic [7:0] sh_load_val;
  logic       sh_shift;
  logic       sh_in;
  logic [7:0] sh_data;
  logic       sh_msb;
  logic       sh_last;

  cmd_op_e    op;

  // cmd_done only counts while a command is outstanding.
  assign done_ev    = wait_done & cmd_done;
  assign wr_cand    = tx_ready;
  assign rd_cand    = rd_pend & rx_ready;
  assign start_xfer = (state == ST_IDLE) & en & (wr_cand | rd_cand);
  assign pick_rd    = rd_cand & (~wr_cand | ~WR_PRIORITY);
  assign busy       = (state != ST_IDLE);

  i3c_bit_shifter u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sh_load),
    .load_val (sh_load_val),
    .shift    (sh_shift),
    .sin      (sh_in),
    .data     (sh_data),
    .msb      (sh_msb),
    .last     (sh_last)
  );

  // The shifter is reloaded on the completion that ends the phase before each
  // serial phase, so its MSB is already presented when that phase's first
  // command goes out.
  always_comb begin
    sh_load     = 1'b0;
    sh_load_val = 8'h00;
    sh_shift    = 1'b0;
    sh_in       = 1'b0;
    if (done_ev) begin
      case (state)
        ST_START: begin
          sh_load     = 1'b1;
          sh_load_val = {HDR_ADDR, RW_WRITE};
        end
        ST_RSTART: begin
          sh_load     = 1'b1;
          sh_load_val = {addr_q, (is_rd ? RW_READ : RW_WRITE)};
        end
        ST_AACK: begin
          sh_load     = ~rsp_bit;
          sh_load_val = is_rd ? 8'h00 : data_q;
        end
        ST_HDR, ST_ADDR, ST_WDATA: sh_shift = 1'b1;
        ST_RDATA: begin
          sh_shift = 1'b1;
          sh_in    = rsp_bit;
        end
        default: ;
      endcase
    end
  end

  // Opcode and bit are pure functions of registered state, so they cannot
  // move while cmd_valid waits for cmd_ready.
  always_comb begin
    op      = OP_START;
    cmd_bit = 1'b0;
    case (state)
      ST_RSTART: op = OP_RSTART;
      ST_STOP:   op = OP_STOP;
      ST_HDR, ST_ADDR, ST_WDATA: begin
        op      = OP_WRBIT;
        cmd_bit = sh_msb;
      end
      ST_WPAR: begin
        op      = OP_WRBIT;
        cmd_bit = odd_par_bit(data_q);
      end
      ST_HACK, ST_AACK, ST_RDATA, ST_RPAR: op = OP_RDBIT;
      default: op = OP_START;
    endcase
  end

  assign cmd_op = op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wait_done  <= 1'b0;
      rd_pend    <= 1'b0;
      is_rd      <= 1'b0;
      addr_q     <= 7'h00;
      data_q     <= 8'h00;
      cmd_valid  <= 1'b0;
      tx_consume <= 1'b0;
      rx_push    <= 1'b0;
      rx_data    <= 8'h00;
      nack_err   <= 1'b0;
    end else begin
      tx_consume <= 1'b0;
      rx_push    <= 1'b0;
      nack_err   <= 1'b0;

      // A request arriving while one is pending is simply absorbed.
      if (start_xfer && pick_rd) begin
        rd_pend <= 1'b0;
      end else if (rd_req) begin
        rd_pend <= 1'b1;
      end

      if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
        wait_done <= 1'b1;
      end

      if (start_xfer) begin
        state     <= ST_START;
        cmd_valid <= 1'b1;
        is_rd     <= pick_rd;
        addr_q    <= dyn_addr;
        data_q    <= tx_data;
      end else if (done_ev) begin
        wait_done <= 1'b0;
        cmd_valid <= 1'b1;
        case (state)
          ST_START:  state <= ST_HDR;
          ST_HDR:    if (sh_last) state <= ST_HACK;
          ST_HACK: begin
            if (rsp_bit) begin
              state    <= ST_STOP;
              nack_err <= 1'b1;
            end else begin
              state <= ST_RSTART;
            end
          end
          ST_RSTART: state <= ST_ADDR;
          ST_ADDR:   if (sh_last) state <= ST_AACK;
          ST_AACK: begin
            if (rsp_bit) begin
              state    <= ST_STOP;
              nack_err <= 1'b1;
            end else begin
              state <= is_rd ? ST_RDATA : ST_WDATA;
            end
          end
          ST_WDATA:  if (sh_last) state <= ST_WPAR;
          ST_WPAR: begin
            state      <= ST_STOP;
            tx_consume <= 1'b1;
          end
          ST_RDATA:  if (sh_last) state <= ST_RPAR;
          ST_RPAR: begin
            state   <= ST_STOP;
            rx_data <= sh_data;
            rx_push <= 1'b1;
          end
          default: begin
            state     <= ST_IDLE;
            cmd_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i3c_sdr_xfer_ctrl.sv
// tb/tb_i3c_sdr_xfer_ctrl.sv - directed self-checking bench for i3c_sdr_xfer_ctrl
module tb_i3c_sdr_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en, tx_ready, rd_req, rx_ready;
  logic [6:0] dyn_addr;
  logic [7:0] tx_data;
  logic       tx_consume, rx_push, busy, nack_err;
  logic [7:0] rx_data;
  logic       cmd_valid, cmd_bit, cmd_ready, cmd_done, rsp_bit;
  logic [2:0] cmd_op;

  int checks = 0;
  int errors = 0;

  // PHY model configuration and observations
  int   stall_cfg = 0;
  int   done_dly = 1;
  int   stray_req = 0;
  int   stall_cnt = 0;
  int   done_cnt = 0;
  int   stab_viol = 0;
  logic pend_rsp = 1'b0;
  logic prev_pending = 1'b0;
  logic [3:0] prev_cmd = 4'h0;
  logic [3:0] log_q[$];
  logic [3:0] exp_q[$];
  logic       rsp_q[$];
  int   n_consume = 0, n_push = 0, n_nack = 0, n_busy_rise = 0;
  logic [7:0] last_rx = 8'h00;
  logic busy_d = 1'b0;

  always #5 clk = ~clk;

  i3c_sdr_xfer_ctrl #(.HDR_ADDR(7'h7E), .WR_PRIORITY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dyn_addr(dyn_addr),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_consume(tx_consume),
    .rd_req(rd_req), .rx_ready(rx_ready), .rx_data(rx_data), .rx_push(rx_push),
    .busy(busy), .nack_err(nack_err), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_bit(cmd_bit), .cmd_ready(cmd_ready), .cmd_done(cmd_done), .rsp_bit(rsp_bit)
  );

  // PHY model plus pulse monitor, evaluated 2 time units after each edge.
  initial begin
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    rsp_bit   = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      cmd_done = 1'b0;
      if (!rst_n) begin
        done_cnt = 0;
        stall_cnt = 0;
        cmd_ready = 1'b0;
        prev_pending = 1'b0;
      end else begin
        if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) begin
            cmd_done = 1'b1;
            rsp_bit  = pend_rsp;
          end
        end else if (stray_req > 0 && (!cmd_valid || stall_cnt < stall_cfg)) begin
          cmd_done = 1'b1;
          rsp_bit  = 1'b1;
          stray_req--;
        end
        if (cmd_valid) begin
          if (prev_pending && ({cmd_op, cmd_bit} !== prev_cmd)) stab_viol++;
          if (stall_cnt < stall_cfg) begin
            cmd_ready = 1'b0;
            stall_cnt++;
            prev_pending = 1'b1;
            prev_cmd = {cmd_op, cmd_bit};
          end else begin
            cmd_ready = 1'b1;
            stall_cnt = 0;
            prev_pending = 1'b0;
            log_q.push_back({cmd_op, (cmd_op == 3'd3) ? cmd_bit : 1'b0});
            done_cnt = done_dly;
            if (cmd_op == 3'd4 && rsp_q.size() > 0) pend_rsp = rsp_q.pop_front();
            else pend_rsp = 1'b0;
          end
        end else begin
          cmd_ready = 1'b0;
          prev_pending = 1'b0;
        end
      end
      if (tx_consume === 1'b1) n_consume++;
      if (nack_err === 1'b1) n_nack++;
      if (rx_push === 1'b1) begin
        n_push++;
        last_rx = rx_data;
      end
      if (busy === 1'b1 && busy_d !== 1'b1) n_busy_rise++;
      busy_d = busy;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Expected-sequence builders: entries are {op, bit}; bit is 0 for non-WRBIT.
  task automatic add_op(input logic [2:0] op);
    exp_q.push_back({op, 1'b0});
  endtask

  task automatic add_wr(input logic b);
    exp_q.push_back({3'd3, b});
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) add_wr(b[i]);
  endtask

  task automatic add_rd(input int n);
    for (int i = 0; i < n; i++) add_op(3'd4);
  endtask

  task automatic push_rsp_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) rsp_q.push_back(b[i]);
  endtask

  function automatic int seq_diff();
    int n;
    n = (log_q.size() > exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i >= log_q.size() || i >= exp_q.size()) return i;
      if (log_q[i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] got_at(input int i);
    return (i < log_q.size()) ? log_q[i] : 4'hF;
  endfunction

  function automatic logic [3:0] exp_at(input int i);
    return (i < exp_q.size()) ? exp_q[i] : 4'hF;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_stats();
    log_q.delete();
    exp_q.delete();
    n_consume = 0;
    n_push = 0;
    n_nack = 0;
    n_busy_rise = 0;
    stab_viol = 0;
  endtask

  task automatic pulse_rd_req();
    rd_req = 1'b1;
    cycles(1);
    rd_req = 1'b0;
  endtask

  // Waits for one transfer (busy rise then fall); acts as the regfile by
  // clearing tx_ready when the byte is consumed.
  task automatic wait_xfer(input string nm);
    int t;
    t = 0;
    while (busy !== 1'b1 && t < 200) begin
      cycles(1);
      if (tx_consume === 1'b1) tx_ready = 1'b0;
      t++;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s start_timeout busy=%b required 1", nm, busy);
      return;
    end
    t = 0;
    while (busy === 1'b1 && t < 3000) begin
      cycles(1);
      if (tx_consume === 1'b1) tx_ready = 1'b0;
      t++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end_timeout busy=%b required 0", nm, busy);
    end
  endtask

  task automatic check_seq(input string nm);
    int idx;
    idx = seq_diff();
    checks++;
    if (idx >= 0) begin
      errors++;
      $display("FAIL %s_seq idx %0d got %h (len %0d) required %h (len %0d)",
               nm, idx, got_at(idx), log_q.size(), exp_at(idx), exp_q.size());
    end
  endtask

  task automatic build_write(input logic [6:0] a, input logic [7:0] d, input logic t);
    add_op(3'd0); add_byte(8'hFC); add_rd(1); add_op(3'd1);
    add_byte({a, 1'b0}); add_rd(1); add_byte(d); add_wr(t); add_op(3'd2);
  endtask

  task automatic build_read(input logic [6:0] a);
    add_op(3'd0); add_byte(8'hFC); add_rd(1); add_op(3'd1);
    add_byte({a, 1'b1}); add_rd(1); add_rd(8); add_rd(1); add_op(3'd2);
  endtask

  task automatic test_reset();
    en = 1'b0; dyn_addr = 7'h00; tx_ready = 1'b0; tx_data = 8'h00;
    rd_req = 1'b0; rx_ready = 1'b0; rst_n = 1'b0;
    cycles(3);
    checks++;
    if ({cmd_valid, busy, tx_consume, rx_push, nack_err, cmd_bit} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b required 000000",
               {cmd_valid, busy, tx_consume, rx_push, nack_err, cmd_bit});
    end
    checks++;
    if (cmd_op !== 3'd0) begin
      errors++;
      $display("FAIL reset_op got %0d required 0", cmd_op);
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx_data got %h required 00", rx_data);
    end
    rst_n = 1'b1;
    tx_data = 8'hA5; dyn_addr = 7'h12; tx_ready = 1'b1;
    clr_stats();
    cycles(10);
    checks++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0 || n_busy_rise != 0) begin
      errors++;
      $display("FAIL en_gate busy=%b cmd_valid=%b rises=%0d required 0 0 0",
               busy, cmd_valid, n_busy_rise);
    end
  endtask

  task automatic test_write();
    clr_stats();
    en = 1'b1;
    cycles(1);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL write_latency valid=%b op=%0d busy=%b required 1 0 1",
               cmd_valid, cmd_op, busy);
    end
    tx_data = 8'hFF;
    dyn_addr = 7'h55;
    wait_xfer("write");
    build_write(7'h12, 8'hA5, 1'b1);
    check_seq("write");
    cycles(10);
    checks++;
    if (n_consume != 1) begin
      errors++;
      $display("FAIL write_consume got %0d required 1", n_consume);
    end
    checks++;
    if (n_busy_rise != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL write_busy rises=%0d busy=%b required 1 0", n_busy_rise, busy);
    end
  endtask

  task automatic test_read();
    clr_stats();
    en = 1'b0; tx_ready = 1'b0; rx_ready = 1'b1; dyn_addr = 7'h12;
    pulse_rd_req();
    cycles(1);
    pulse_rd_req();
    cycles(5);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL read_en_hold busy=%b required 0", busy);
    end
    rsp_q.push_back(1'b0); rsp_q.push_back(1'b0);
    push_rsp_byte(8'h3C);
    rsp_q.push_back(1'b1);
    en = 1'b1;
    wait_xfer("read");
    build_read(7'h12);
    check_seq("read");
    checks++;
    if (n_push != 1 || last_rx !== 8'h3C) begin
      errors++;
      $display("FAIL read_push count=%0d data=%h required 1 3c", n_push, last_rx);
    end
    cycles(10);
    checks++;
    if (rx_data !== 8'h3C || n_push != 1 || n_busy_rise != 1 || n_nack != 0) begin
      errors++;
      $display("FAIL read_after rx=%h push=%0d rises=%0d nack=%0d required 3c 1 1 0",
               rx_data, n_push, n_busy_rise, n_nack);
    end
  endtask

  task automatic test_hdr_nack();
    clr_stats();
    rsp_q.push_back(1'b1);
    tx_data = 8'h5A; dyn_addr = 7'h12; tx_ready = 1'b1;
    wait_xfer("hdr_nack");
    checks++;
    if (n_nack != 1 || n_consume != 0) begin
      errors++;
      $display("FAIL hdr_nack_pulse nack=%0d consume=%0d required 1 0", n_nack, n_consume);
    end
    wait_xfer("hdr_retry");
    add_op(3'd0); add_byte(8'hFC); add_rd(1); add_op(3'd2);
    build_write(7'h12, 8'h5A, 1'b1);
    check_seq("hdr_nack");
    checks++;
    if (n_nack != 1 || n_consume != 1) begin
      errors++;
      $display("FAIL hdr_retry_pulse nack=%0d consume=%0d required 1 1", n_nack, n_consume);
    end
    clr_stats();
    rsp_q.push_back(1'b0); rsp_q.push_back(1'b1);
    pulse_rd_req();
    wait_xfer("addr_nack");
    add_op(3'd0); add_byte(8'hFC); add_rd(1); add_op(3'd1);
    add_byte(8'h25); add_rd(1); add_op(3'd2);
    check_seq("addr_nack");
    cycles(10);
    checks++;
    if (n_nack != 1 || n_push != 0 || n_busy_rise != 1) begin
      errors++;
      $display("FAIL addr_nack_drop nack=%0d push=%0d rises=%0d required 1 0 1",
               n_nack, n_push, n_busy_rise);
    end
  endtask

  task automatic test_arbitration();
    clr_stats();
    en = 1'b0; rx_ready = 1'b1; tx_data = 8'h81; dyn_addr = 7'h03;
    pulse_rd_req();
    tx_ready = 1'b1;
    rsp_q.push_back(1'b0); rsp_q.push_back(1'b0);
    rsp_q.push_back(1'b0); rsp_q.push_back(1'b0);
    push_rsp_byte(8'h96);
    rsp_q.push_back(1'b0);
    cycles(2);
    en = 1'b1;
    wait_xfer("arb_write");
    wait_xfer("arb_read");
    build_write(7'h03, 8'h81, 1'b1);
    build_read(7'h03);
    check_seq("arb");
    checks++;
    if (n_consume != 1 || n_push != 1 || last_rx !== 8'h96) begin
      errors++;
      $display("FAIL arb_pulses consume=%0d push=%0d rx=%h required 1 1 96",
               n_consume, n_push, last_rx);
    end
    clr_stats();
    rx_ready = 1'b0;
    pulse_rd_req();
    cycles(20);
    checks++;
    if (n_busy_rise != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL arb_rx_hold rises=%0d busy=%b required 0 0", n_busy_rise, busy);
    end
    rsp_q.push_back(1'b0); rsp_q.push_back(1'b0);
    push_rsp_byte(8'h0F);
    rsp_q.push_back(1'b0);
    rx_ready = 1'b1;
    wait_xfer("arb_held_read");
    checks++;
    if (n_push != 1 || last_rx !== 8'h0F) begin
      errors++;
      $display("FAIL arb_held_push count=%0d data=%h required 1 0f", n_push, last_rx);
    end
  endtask

  task automatic test_backpressure();
    clr_stats();
    stall_cfg = 5; done_dly = 3; stray_req = 4;
    tx_data = 8'hA5; dyn_addr = 7'h12;
    cycles(3);
    tx_ready = 1'b1;
    wait_xfer("bp");
    build_write(7'h12, 8'hA5, 1'b1);
    check_seq("bp");
    checks++;
    if (stab_viol != 0) begin
      errors++;
      $display("FAIL bp_stable violations=%0d required 0", stab_viol);
    end
    checks++;
    if (n_consume != 1 || n_nack != 0 || stray_req != 0) begin
      errors++;
      $display("FAIL bp_pulses consume=%0d nack=%0d strays_left=%0d required 1 0 0",
               n_consume, n_nack, stray_req);
    end
    stall_cfg = 0; done_dly = 1; stray_req = 0;
    cycles(5);
  endtask

  task automatic test_reset_mid();
    int t;
    clr_stats();
    tx_data = 8'hA5; dyn_addr = 7'h12; tx_ready = 1'b1;
    t = 0;
    while (log_q.size() < 25 && t < 500) begin
      cycles(1);
      t++;
    end
    checks++;
    if (log_q.size() != 25) begin
      errors++;
      $display("FAIL rstmid_reach len=%0d required 25", log_q.size());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_valid, busy, tx_consume, rx_push, nack_err, cmd_bit} !== 6'b0 ||
        cmd_op !== 3'd0 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_outputs ctl=%b op=%0d rx=%h required 000000 0 00",
               {cmd_valid, busy, tx_consume, rx_push, nack_err, cmd_bit}, cmd_op, rx_data);
    end
    checks++;
    if (n_consume != 0) begin
      errors++;
      $display("FAIL rstmid_consume got %0d required 0", n_consume);
    end
    cycles(2);
    clr_stats();
    rst_n = 1'b1;
    wait_xfer("rstmid");
    build_write(7'h12, 8'hA5, 1'b1);
    check_seq("rstmid");
    checks++;
    if (n_consume != 1) begin
      errors++;
      $display("FAIL rstmid_redo_consume got %0d required 1", n_consume);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_hdr_nack();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
